sindoku_btn_pulser: RTL
=======================

SINDOKU_BTN_PULSER -- requirements
Module: sindoku_btn_pulser

Interface
REQ-001 Parameter DB_CYCLES, default 1000000 (10 ms at 100 MHz), is the number of stable cycles that qualifies a press or a release; legal minimum is 2.
REQ-002 Clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 BtnR, BtnL, BtnU, BtnD, BtnC  input  1 each  raw, asynchronous, bouncing push-button levels; high means pressed.
REQ-005 BtnR_Pulse, BtnL_Pulse, BtnU_Pulse, BtnD_Pulse, BtnC_Pulse  output  1 each  one-cycle pulse per debounced press; feeds the sindoku R/L/U/D/C inputs.
REQ-006 BtnR_Db, BtnL_Db, BtnU_Db, BtnD_Db, BtnC_Db  output  1 each  debounced button level.

Function
REQ-007 Each raw input SHALL pass through a 2-flop synchronizer before its FSM; the FSM sees only the second flop, called s.
REQ-008 Each button SHALL have its own FSM: IDLE, WAIT_PRESS, PULSE, HELD, WAIT_REL.
REQ-009 IDLE: if s=1, go to WAIT_PRESS with counter cleared to 0; otherwise stay.
REQ-010 WAIT_PRESS, s=0: return to IDLE (bounce rejected).
REQ-011 WAIT_PRESS, s=1: increment the counter; when counter=DB_CYCLES-1, go to PULSE.
REQ-012 PULSE: lasts exactly one cycle, then HELD; Btn*_Pulse SHALL be 1 only in PULSE.
REQ-013 HELD: if s=0, go to WAIT_REL with counter cleared; otherwise stay, with no further pulses however long the button is held.
REQ-014 WAIT_REL, s=1: return to HELD (release bounce, no pulse).
REQ-015 WAIT_REL, s=0: increment the counter; when counter=DB_CYCLES-1, go to IDLE.
REQ-016 Btn*_Db SHALL be 1 in PULSE, HELD and WAIT_REL, and 0 in IDLE and WAIT_PRESS.
REQ-017 Latency: with the raw input stable high from before edge 0, Pulse SHALL be high exactly between edge DB_CYCLES+2 and edge DB_CYCLES+3.
REQ-018 The counter SHALL be $clog2(DB_CYCLES) bits wide and SHALL never wrap; it is cleared on every state entry.
REQ-019 The five buttons SHALL be fully independent; simultaneous presses SHALL give pulses in the same cycle, with no prioritisation or masking.
REQ-020 Outputs SHALL be registered (decoded from the state register), with no combinational path from the raw inputs.

Reset
REQ-021 While Reset=1, immediately and independent of Clk: all synchronizer flops 0, all FSMs in IDLE, all counters 0, all Pulse and Db outputs 0.
REQ-022 Reset asserted mid-press or mid-release SHALL abort that press or release with no pulse.
REQ-023 A button still held after Reset deasserts SHALL be treated as a new press and pulse per REQ-017, with edges counted from deassertion.

Structure
REQ-024 A shared package sindoku_pkg SHALL hold the FSM state encoding (5 states, 3-bit localparams) and the DB_CYCLES default.
REQ-025 One sub-module, btn_debounce (synchronizer + FSM + counter, ports Clk, Reset, btn_in, pulse, db), SHALL be instantiated five times by sindoku_btn_pulser.
REQ-026 The implementation SHALL contain no other logic beyond the five instances and port wiring.

Verification
REQ-027 The bench SHALL use DB_CYCLES=4 and a 10 ns clock; all stimulus SHALL change 1 ns after a rising edge.
REQ-028 Clean press: BtnC high for 20 cycles from edge 0 -> BtnC_Pulse=1 exactly between edges 6 and 7; BtnC_Db rises at edge 6; BtnC_Db falls 4 cycles after the synchronized release is seen.
REQ-029 Bounce: BtnR 1,1,0,1 then held 20 cycles -> exactly one BtnR_Pulse, 6 edges after the last rising transition.
REQ-030 Glitch: BtnU high for 3 cycles, then low -> no pulse and BtnU_Db stays 0.
REQ-031 Hold and release bounce: BtnD held 100 cycles, then 0,1,0 and low 10 cycles, then pressed again -> exactly two pulses in total, one per press; BtnD_Db stays 1 through the release bounce.
REQ-032 Simultaneous and reset: BtnL and BtnU rise on the same edge -> both pulses in the same cycle; separately, Reset during WAIT_PRESS -> outputs 0 at once and no pulse, and the still-held button pulses 6 edges after deassertion.

Source files
------------

// File: rtl/sindoku_btn_pulser_pkg.sv
// Shared definitions for the sindoku push-button pulser: FSM state encoding and
// the default debounce interval.
package sindoku_pkg;

    // 10 ms at 100 MHz.
    localparam int unsigned DbCyclesDefault = 1000000;

    localparam int unsigned StateW = 3;

    localparam logic [StateW-1:0] StIdleEnc      = 3'd0;
    localparam logic [StateW-1:0] StWaitPressEnc = 3'd1;
    localparam logic [StateW-1:0] StPulseEnc     = 3'd2;
    localparam logic [StateW-1:0] StHeldEnc      = 3'd3;
    localparam logic [StateW-1:0] StWaitRelEnc   = 3'd4;

    typedef enum logic [StateW-1:0] {
        StIdle      = StIdleEnc,
        StWaitPress = StWaitPressEnc,
        StPulse     = StPulseEnc,
        StHeld      = StHeldEnc,
        StWaitRel   = StWaitRelEnc
    } btn_state_e;

endpackage

// File: rtl/sindoku_btn_pulser_if.sv
// Button bundle between the board pads and the pulser: raw levels in, one-cycle
// press pulses and debounced levels out.
interface sindoku_btn_pulser_if;

    logic BtnR, BtnL, BtnU, BtnD, BtnC;
    logic BtnR_Pulse, BtnL_Pulse, BtnU_Pulse, BtnD_Pulse, BtnC_Pulse;
    logic BtnR_Db, BtnL_Db, BtnU_Db, BtnD_Db, BtnC_Db;

    modport master (
        output BtnR, BtnL, BtnU, BtnD, BtnC,
        input  BtnR_Pulse, BtnL_Pulse, BtnU_Pulse, BtnD_Pulse, BtnC_Pulse,
        input  BtnR_Db, BtnL_Db, BtnU_Db, BtnD_Db, BtnC_Db
    );

    modport slave (
        input  BtnR, BtnL, BtnU, BtnD, BtnC,
        output BtnR_Pulse, BtnL_Pulse, BtnU_Pulse, BtnD_Pulse, BtnC_Pulse,
        output BtnR_Db, BtnL_Db, BtnU_Db, BtnD_Db, BtnC_Db
    );

endinterface

// File: rtl/sindoku_btn_pulser_debounce.sv
// Single-button conditioner: 2-flop synchronizer, press/release debounce FSM and
// stability counter, with registered pulse and level outputs.
module btn_debounce
    import sindoku_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_in,
    output logic pulse,
    output logic db
);

    localparam int unsigned    CntW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    logic            sync1_q;
    logic            s_q;
    btn_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            pulse_q;
    logic            db_q;

    // Outputs are set on the same edge as the state they decode, so they track state_q.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            s_q     <= sync1_q;
            unique case (state_q)
                StIdle: begin
                    if (s_q) begin
                        state_q <= StWaitPress;
                        cnt_q   <= '0;
                    end
                end
                StWaitPress: begin
                    if (!s_q) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StPulse;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                        db_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPulse: begin
                    state_q <= StHeld;
                    cnt_q   <= '0;
                    pulse_q <= 1'b0;
                end
                StHeld: begin
                    if (!s_q) begin
                        state_q <= StWaitRel;
                        cnt_q   <= '0;
                    end
                end
                StWaitRel: begin
                    if (s_q) begin
                        state_q <= StHeld;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        db_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    pulse_q <= 1'b0;
                    db_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pulse = pulse_q;
    assign db    = db_q;

endmodule

// File: rtl/sindoku_btn_pulser.sv
// Five independent debounced push-button pulsers feeding the sindoku R/L/U/D/C
// inputs.
module sindoku_btn_pulser
    import sindoku_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
    input logic                 Clk,
    input logic                 Reset,
    sindoku_btn_pulser_if.slave btn_io
);

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_r (
        .Clk    (Clk),
        .Reset  (Reset),
        .btn_in (btn_io.BtnR),
        .pulse  (btn_io.BtnR_Pulse),
        .db     (btn_io.BtnR_Db)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_l (
        .Clk    (Clk),
        .Reset  (Reset),
        .btn_in (btn_io.BtnL),
        .pulse  (btn_io.BtnL_Pulse),
        .db     (btn_io.BtnL_Db)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_u (
        .Clk    (Clk),
        .Reset  (Reset),
        .btn_in (btn_io.BtnU),
        .pulse  (btn_io.BtnU_Pulse),
        .db     (btn_io.BtnU_Db)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_d (
        .Clk    (Clk),
        .Reset  (Reset),
        .btn_in (btn_io.BtnD),
        .pulse  (btn_io.BtnD_Pulse),
        .db     (btn_io.BtnD_Db)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_c (
        .Clk    (Clk),
        .Reset  (Reset),
        .btn_in (btn_io.BtnC),
        .pulse  (btn_io.BtnC_Pulse),
        .db     (btn_io.BtnC_Db)
    );

endmodule
